// File: rtl/noc_client_injector_pkg.sv
// ---------------------------------------------------------------------------
// noc_client_injector_pkg
//   Shared types and constants for the client-side NoC injection stage.
//   - noc_inj_pkt_t : {dest, data} packet as it travels on the NoC channel,
//                     dest in the MSBs (default widths).
//   - inj_max_credit: usable downstream credits for a given VC FIFO depth.
//                     One slot is reserved, so the count is one below the
//                     FIFO depth.
// ---------------------------------------------------------------------------
package noc_client_injector_pkg;

  localparam int DEFAULT_A_W           = 3;
  localparam int DEFAULT_D_W           = 8;
  localparam int DEFAULT_VC_FIFO_DEPTH = 4;
  localparam int DEFAULT_INJ_Q_DEPTH   = 4;

  typedef struct packed {
    logic [DEFAULT_A_W-1:0] dest;
    logic [DEFAULT_D_W-1:0] data;
  } noc_inj_pkt_t;

  function automatic int inj_max_credit(input int vc_fifo_depth);
    return vc_fifo_depth - 1;
  endfunction

endpackage

// File: rtl/noc_inj_vc_fifo.sv
// ---------------------------------------------------------------------------
// noc_inj_vc_fifo
//   Single-VC circular buffer of Q_DEPTH entries (Q_DEPTH a power of two).
//   The head entry is presented combinationally on rdata so the parent can
//   register it in the same cycle it pops.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, wdata     write request and data (ignored when full without a pop)
//   pop             read request (ignored when empty)
//   rdata           current head entry
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module noc_inj_vc_fifo #(
  parameter int W       = 11,
  parameter int Q_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(Q_DEPTH));
  assign rdata = mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push into a full buffer is
  // still accepted then. Pointers wrap naturally at the power-of-two depth.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty count masks whatever it holds.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/noc_client_injector.sv
// ---------------------------------------------------------------------------
// noc_client_injector
//   Client-side injection stage in front of a level-0 switch port. Client
//   packets are queued per VC; a round-robin arbiter picks one VC per cycle
//   among those with a queued packet and a downstream credit, and the chosen
//   packet is driven (registered) onto the NoC channel for one cycle.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   client handshake; in_ready depends on in_vc
//   in_vc, in_dest,     VC index (clamped to VC_W-1), destination, payload
//   in_data
//   tx_vc_target        one-hot VC of the packet on the channel, 0 = idle
//   tx_packet           {dest, data}; only meaningful when tx_vc_target != 0
//   tx_vc_credit_gnt    per-VC credit return pulses from the switch
//   idle                all queues empty and all credits returned
//   err_credit_ovf      sticky: credit returned to a VC already at maximum
// ---------------------------------------------------------------------------
module noc_client_injector
  import noc_client_injector_pkg::*;
#(
  parameter int N             = 4,
  parameter int A_W           = 3,
  parameter int D_W           = DEFAULT_D_W,
  parameter int VC_W          = 4,
  parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
  parameter int Q_DEPTH       = DEFAULT_INJ_Q_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(VC_W)-1:0] in_vc,
  input  logic [A_W-1:0]          in_dest,
  input  logic [D_W-1:0]          in_data,
  output logic [VC_W-1:0]         tx_vc_target,
  output logic [A_W+D_W-1:0]      tx_packet,
  input  logic [VC_W-1:0]         tx_vc_credit_gnt,
  output logic                    idle,
  output logic                    err_credit_ovf
);

  localparam int VI_W   = $clog2(VC_W);
  localparam int P_W    = A_W + D_W;
  localparam int MAX_CR = inj_max_credit(VC_FIFO_DEPTH);
  localparam int CR_W   = $clog2(MAX_CR + 1);

  // Catch parameter sets the datapath cannot represent.
  if (A_W < $clog2(N) + 1) begin : g_bad_a_w
    $error("noc_client_injector: A_W too narrow for N clients");
  end
  if ((1 << $clog2(Q_DEPTH)) != Q_DEPTH || Q_DEPTH < 2) begin : g_bad_q_depth
    $error("noc_client_injector: Q_DEPTH must be a power of two >= 2");
  end

  logic [VI_W-1:0] vc_sel;
  logic [VC_W-1:0] push_vec, pop_vec, full_vec, empty_vec, elig;
  logic [P_W-1:0]  head [VC_W];
  logic [CR_W-1:0] credit_q [VC_W];
  logic [CR_W-1:0] credit_d [VC_W];
  logic [VI_W-1:0] rr_q, rr_d;
  logic            grant_valid;
  logic [VI_W-1:0] grant_idx;
  int              cand;
  logic [VC_W-1:0] tx_vc_target_q, tx_vc_target_d;
  logic [P_W-1:0]  tx_packet_q, tx_packet_d;
  logic            err_q, err_d;

  // Out-of-range VC indices fold onto the last VC instead of being dropped;
  // with a power-of-two VC count every index is already legal.
  if (VC_W == (1 << VI_W)) begin : g_vc_direct
    assign vc_sel = in_vc;
  end else begin : g_vc_clamp
    assign vc_sel = (32'(in_vc) >= VC_W) ? VI_W'(VC_W - 1) : in_vc;
  end

  // A full queue still accepts when it is being drained in the same cycle.
  assign in_ready = rst && (!full_vec[vc_sel] || pop_vec[vc_sel]);

  always_comb begin
    push_vec = '0;
    for (int v = 0; v < VC_W; v++) begin
      push_vec[v] = in_valid && in_ready && (vc_sel == VI_W'(v));
    end
  end

  for (genvar v = 0; v < VC_W; v++) begin : g_vc
    noc_inj_vc_fifo #(
      .W      (P_W),
      .Q_DEPTH(Q_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push_vec[v]),
      .pop  (pop_vec[v]),
      .wdata({in_dest, in_data}),
      .rdata(head[v]),
      .full (full_vec[v]),
      .empty(empty_vec[v])
    );
  end

  // Round-robin scan starting at rr_q; the first eligible VC wins.
  always_comb begin
    elig        = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int v = 0; v < VC_W; v++) begin
      elig[v] = !empty_vec[v] && (credit_q[v] != '0);
    end
    for (int i = 0; i < VC_W; i++) begin
      cand = (int'(rr_q) + i) % VC_W;
      if (!grant_valid && elig[VI_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = VI_W'(cand);
      end
    end
  end

  always_comb begin
    pop_vec = '0;
    for (int v = 0; v < VC_W; v++) begin
      pop_vec[v] = grant_valid && (grant_idx == VI_W'(v));
    end
    if (!grant_valid) begin
      rr_d = rr_q;
    end else if (grant_idx == VI_W'(VC_W - 1)) begin
      rr_d = '0;
    end else begin
      rr_d = grant_idx + 1'b1;
    end
  end

  // Credits: a grant and a return on the same VC cancel. A return with the
  // counter already full saturates and latches the overflow flag.
  always_comb begin
    err_d = err_q;
    for (int v = 0; v < VC_W; v++) begin
      credit_d[v] = credit_q[v];
      if (tx_vc_credit_gnt[v] && !pop_vec[v]) begin
        if (credit_q[v] == CR_W'(MAX_CR)) begin
          err_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + 1'b1;
        end
      end else if (pop_vec[v] && !tx_vc_credit_gnt[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end
    end
  end

  // The channel registers the granted head; the packet field keeps its old
  // value in idle cycles.
  always_comb begin
    tx_vc_target_d = pop_vec;
    tx_packet_d    = grant_valid ? head[grant_idx] : tx_packet_q;
  end

  always_comb begin
    idle = &empty_vec;
    for (int v = 0; v < VC_W; v++) begin
      if (credit_q[v] != CR_W'(MAX_CR)) begin
        idle = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q           <= '0;
      tx_vc_target_q <= '0;
      tx_packet_q    <= '0;
      err_q          <= 1'b0;
      for (int v = 0; v < VC_W; v++) begin
        credit_q[v] <= CR_W'(MAX_CR);
      end
    end else begin
      rr_q           <= rr_d;
      tx_vc_target_q <= tx_vc_target_d;
      tx_packet_q    <= tx_packet_d;
      err_q          <= err_d;
      for (int v = 0; v < VC_W; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  assign tx_vc_target   = tx_vc_target_q;
  assign tx_packet      = tx_packet_q;
  assign err_credit_ovf = err_q;

endmodule

// File: tb/tb_noc_client_injector.sv
// ---------------------------------------------------------------------------
// tb_noc_client_injector
//   Self-checking bench for noc_client_injector: a directed vector table, a
//   hand-written full-queue / mid-stream reset sequence and a randomized run,
//   all tracked by a queue-based reference model of the injector.
// ---------------------------------------------------------------------------
module tb_noc_client_injector;
   import noc_client_injector_pkg::*;

   localparam int VC_W    = 4;
   localparam int Q_DEPTH = 4;
   localparam int MAX_CR  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_vc;
   logic [2:0]  in_dest;
   logic [7:0]  in_data;
   logic [3:0]  tx_vc_target;
   logic [10:0] tx_packet;
   logic [3:0]  tx_vc_credit_gnt;
   logic        idle;
   logic        err_credit_ovf;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model state: packet queues, credit counts, round-robin start,
   // sticky error and the channel contents expected after the last edge.
   noc_inj_pkt_t m_q [VC_W][$];
   int           m_cred [VC_W];
   int           m_rr;
   logic         m_err;
   logic [3:0]   m_target;
   logic [10:0]  m_packet;
   logic         m_ready;
   logic         sampled_ready;

   typedef struct {
      logic        valid;
      logic [1:0]  vc;
      logic [2:0]  dest;
      logic [7:0]  data;
      logic [3:0]  gnt;
      logic        exp_ready;
      logic [3:0]  exp_target;
      logic [10:0] exp_packet;
      logic        exp_idle;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   noc_client_injector #(
      .N(4), .A_W(3), .D_W(8), .VC_W(4), .VC_FIFO_DEPTH(4), .Q_DEPTH(4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_vc           (in_vc),
      .in_dest         (in_dest),
      .in_data         (in_data),
      .tx_vc_target    (tx_vc_target),
      .tx_packet       (tx_packet),
      .tx_vc_credit_gnt(tx_vc_credit_gnt),
      .idle            (idle),
      .err_credit_ovf  (err_credit_ovf)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic v, input logic [1:0] vc, input logic [2:0] dest,
                         input logic [7:0] data, input logic [3:0] gnt, input logic er,
                         input logic [3:0] et, input logic [10:0] ep, input logic ei,
                         input logic ee);
      vec_t r;
      r.valid = v; r.vc = vc; r.dest = dest; r.data = data; r.gnt = gnt;
      r.exp_ready = er; r.exp_target = et; r.exp_packet = ep;
      r.exp_idle = ei; r.exp_err = ee;
      vecs.push_back(r);
   endtask

   function automatic void modelReset();
      for (int v = 0; v < VC_W; v++) begin
         m_q[v].delete();
         m_cred[v] = MAX_CR;
      end
      m_rr     = 0;
      m_err    = 1'b0;
      m_target = '0;
      m_packet = '0;
   endfunction

   // First VC, scanning circularly from the round-robin start, that has a
   // queued packet and a credit; -1 when none qualifies.
   function automatic int modelPick();
      for (int i = 0; i < VC_W; i++) begin
         int v = (m_rr + i) % VC_W;
         if (m_q[v].size() > 0 && m_cred[v] > 0) return v;
      end
      return -1;
   endfunction

   function automatic logic modelIdle();
      for (int v = 0; v < VC_W; v++) begin
         if (m_q[v].size() != 0 || m_cred[v] != MAX_CR) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Drive one cycle of inputs (called just after a rising edge), check the
   // combinational ready mid-cycle, then advance the model across the edge.
   task automatic applyStimulus(input logic v, input logic [1:0] vc, input logic [2:0] dest,
                                input logic [7:0] data, input logic [3:0] gnt);
      int           g;
      noc_inj_pkt_t pkt;
      in_valid = v; in_vc = vc; in_dest = dest; in_data = data; tx_vc_credit_gnt = gnt;
      g = modelPick();
      m_ready = (m_q[vc].size() - ((g == int'(vc)) ? 1 : 0)) < Q_DEPTH;
      @(negedge clk);
      sampled_ready = in_ready;
      checkVal("in_ready", 32'(sampled_ready), 32'(m_ready));
      @(posedge clk);
      if (g >= 0) begin
         pkt      = m_q[g].pop_front();
         m_target = 4'(1 << g);
         m_packet = pkt;
         m_rr     = (g + 1) % VC_W;
      end else begin
         m_target = '0;
      end
      if (v && m_ready) begin
         pkt.dest = dest;
         pkt.data = data;
         m_q[vc].push_back(pkt);
      end
      for (int i = 0; i < VC_W; i++) begin
         if (gnt[i] && g != i && m_cred[i] == MAX_CR) m_err = 1'b1;
         else m_cred[i] = m_cred[i] - ((g == i) ? 1 : 0) + (gnt[i] ? 1 : 0);
      end
      #1;
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, "_target"}, 32'(tx_vc_target), 32'(m_target));
      if (m_target != '0) checkVal({tag, "_packet"}, 32'(tx_packet), 32'(m_packet));
      checkVal({tag, "_idle"}, 32'(idle), 32'(modelIdle()));
      checkVal({tag, "_err"}, 32'(err_credit_ovf), 32'(m_err));
   endtask

   // Assert reset at the current time, check the held-in-reset outputs, then
   // release on a falling edge and realign just after a rising edge.
   task automatic doReset();
      rst = 1'b0; in_valid = 1'b0; in_vc = '0; in_dest = '0; in_data = '0;
      tx_vc_credit_gnt = '0;
      #1;
      checkVal("rst_target", 32'(tx_vc_target), 32'h0);
      checkVal("rst_packet", 32'(tx_packet), 32'h0);
      checkVal("rst_ready", 32'(in_ready), 32'h0);
      checkVal("rst_idle", 32'(idle), 32'h1);
      checkVal("rst_err", 32'(err_credit_ovf), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      modelReset();
   endtask

   // Main sequence: reset, directed table, full-queue and mid-stream reset,
   // then a randomized run against the model.
   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_vc = '0; in_dest = '0; in_data = '0; tx_vc_credit_gnt = '0;
      modelReset();
      #2;
      doReset();

      // Single push on VC2, credit return, five pushes on VC0 against three
      // credits, interleaved VC0/1/3 traffic, grant+return on VC1, overflow.
      addVec(1, 2, 3, 8'hA5, 4'h0, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h0, 1, 4'h4, 11'h3A5, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h0, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h4, 1, 4'h0, 11'h000, 1, 0);
      addVec(1, 0, 0, 8'h10, 4'h0, 1, 4'h0, 11'h000, 0, 0);
      addVec(1, 0, 1, 8'h11, 4'h0, 1, 4'h1, 11'h010, 0, 0);
      addVec(1, 0, 2, 8'h12, 4'h0, 1, 4'h1, 11'h111, 0, 0);
      addVec(1, 0, 3, 8'h13, 4'h0, 1, 4'h1, 11'h212, 0, 0);
      addVec(1, 0, 4, 8'h14, 4'h0, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h1, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h0, 1, 4'h1, 11'h313, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h0, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h1, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h0, 1, 4'h1, 11'h414, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h1, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h1, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h1, 1, 4'h0, 11'h000, 1, 0);
      addVec(1, 0, 1, 8'h20, 4'h0, 1, 4'h0, 11'h000, 0, 0);
      addVec(1, 1, 2, 8'h21, 4'h0, 1, 4'h1, 11'h120, 0, 0);
      addVec(1, 3, 3, 8'h22, 4'h0, 1, 4'h2, 11'h221, 0, 0);
      addVec(1, 0, 4, 8'h23, 4'h0, 1, 4'h8, 11'h322, 0, 0);
      addVec(1, 1, 5, 8'h24, 4'h0, 1, 4'h1, 11'h423, 0, 0);
      addVec(1, 3, 6, 8'h25, 4'h0, 1, 4'h2, 11'h524, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h0, 1, 4'h8, 11'h625, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'hB, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'hB, 1, 4'h0, 11'h000, 1, 0);
      addVec(1, 1, 7, 8'h30, 4'h0, 1, 4'h0, 11'h000, 0, 0);
      addVec(0, 0, 0, 8'h00, 4'h2, 1, 4'h2, 11'h730, 1, 0);
      addVec(0, 0, 0, 8'h00, 4'h0, 1, 4'h0, 11'h000, 1, 0);
      addVec(0, 0, 0, 8'h00, 4'h8, 1, 4'h0, 11'h000, 1, 1);
      addVec(0, 0, 0, 8'h00, 4'h0, 1, 4'h0, 11'h000, 1, 1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].valid, vecs[i].vc, vecs[i].dest, vecs[i].data, vecs[i].gnt);
         checkOutput($sformatf("tbl%0d_model", i));
         checkVal($sformatf("tbl%0d_ready", i), 32'(sampled_ready), 32'(vecs[i].exp_ready));
         checkVal($sformatf("tbl%0d_target", i), 32'(tx_vc_target), 32'(vecs[i].exp_target));
         if (vecs[i].exp_target != '0)
            checkVal($sformatf("tbl%0d_packet", i), 32'(tx_packet), 32'(vecs[i].exp_packet));
         checkVal($sformatf("tbl%0d_idle", i), 32'(idle), 32'(vecs[i].exp_idle));
         checkVal($sformatf("tbl%0d_err", i), 32'(err_credit_ovf), 32'(vecs[i].exp_err));
      end

      // Exhaust VC2 credits and fill its queue, then probe ready per VC.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 2'd2, 3'(i), 8'(8'h40 + i), 4'h0);
         checkOutput($sformatf("fill%0d", i));
      end
      applyStimulus(1'b0, 2'd2, 3'd0, 8'h00, 4'h0);
      checkVal("full_ready_vc2", 32'(sampled_ready), 32'h0);
      checkOutput("full_vc2");
      applyStimulus(1'b0, 2'd0, 3'd0, 8'h00, 4'h0);
      checkVal("full_ready_vc0", 32'(sampled_ready), 32'h1);
      checkOutput("full_vc0");

      // Get a VC0 packet onto the channel with more queued, then reset
      // asynchronously in the middle of the cycle.
      applyStimulus(1'b1, 2'd0, 3'd1, 8'h55, 4'h0);
      checkOutput("mid0");
      applyStimulus(1'b1, 2'd0, 3'd2, 8'h56, 4'h0);
      checkOutput("mid1");
      checkVal("mid_target_live", 32'(tx_vc_target), 32'h1);
      #2;
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 2'd0, 3'd0, 8'h00, 4'h0);
         checkOutput($sformatf("post_rst%0d", i));
         checkVal($sformatf("post_rst%0d_target", i), 32'(tx_vc_target), 32'h0);
         checkVal($sformatf("post_rst%0d_idle", i), 32'(idle), 32'h1);
      end

      // Random traffic; credits come back only for packets actually sent.
      for (int c = 0; c < 600; c++) begin
         logic [3:0] gnt;
         gnt = '0;
         for (int v = 0; v < VC_W; v++) begin
            if (m_cred[v] < MAX_CR && $urandom_range(0, 2) == 0) gnt[v] = 1'b1;
         end
         applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                       3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), gnt);
         checkOutput($sformatf("rnd%0d", c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/noc_client_injector.md
Name: noc_client_injector

Overview:
- Client-side injection stage between a NoC client (traffic generator or compute endpoint) and the `l_rx`/`r_rx` port of a level-0 `pi_switch_top`.
- Accepts packets from the client over valid/ready and holds them in per-VC queues.
- Tracks the downstream switch's per-VC buffer space with credit counters.
- Issues at most one packet per cycle onto the NoC channel (one-hot `vc_target` + `packet`), arbitrating round-robin among VCs that have both a queued packet and a credit.

Parameters:
- N, 4, number of clients in the network.
- A_W, 3, destination address width (`$clog2(N)+1`).
- D_W, `DEFAULT_D_W`, payload width.
- VC_W, 4, number of virtual channels (one-hot `vc_target` width).
- VC_FIFO_DEPTH, `DEFAULT_VC_FIFO_DEPTH`, downstream VC FIFO depth; usable credits = VC_FIFO_DEPTH-1.
- Q_DEPTH, 4, local queue depth per VC (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- in_valid  in  1  client packet valid.
- in_ready  out  1  selected VC queue can accept.
- in_vc  in  `$clog2(VC_W)`  VC index for the packet.
- in_dest  in  A_W  destination address.
- in_data  in  D_W  payload.
- tx_vc_target  out  VC_W  one-hot VC of the packet driven this cycle; 0 = idle. Connects to `noc_if.vc_target`.
- tx_packet  out  A_W+D_W  `{dest, data}`, dest in MSBs. Connects to `noc_if.packet`.
- tx_vc_credit_gnt  in  VC_W  per-VC credit return pulses from the switch. Connects to `noc_if.vc_credit_gnt`.
- idle  out  1  all queues empty and all credits at maximum.
- err_credit_ovf  out  1  sticky; a credit was returned to a VC already at maximum.

Behaviour:
Reset (rst=0):
- Queues empty; credit[v] = VC_FIFO_DEPTH-1 for every VC; RR pointer = 0.
- tx_vc_target = 0, tx_packet = 0, err_credit_ovf = 0.
- in_ready = 0 while rst=0. idle = 1 after reset.

Ingress:
- in_ready = !full[in_vc]; it is combinational on in_vc.
- Push occurs when in_valid && in_ready.
- An in_vc value ≥ VC_W is treated as VC_W-1 (clamped, not dropped).

Egress candidates:
- VC v is eligible when !empty[v] && credit[v] > 0.
- Round-robin grant: scan starts at RR pointer. On grant of v, the pointer moves to (v+1) mod VC_W; it does not move when there is no grant.

Egress outputs:
- Outputs are registered. In the cycle after a grant, tx_vc_target = 1<<v and tx_packet = head of queue v, for exactly one cycle.
- Otherwise tx_vc_target = 0 and tx_packet holds its last value. Verification must not check tx_packet when tx_vc_target = 0.
- Latency:
  - Push into an empty queue with a credit available → grant on the next edge → tx visible 1 cycle later.
  - Minimum 2 cycles in_valid→tx_vc_target.
- Throughput is 1 packet/cycle sustained across VCs. One VC alone is limited by its credits.

Credits:
- Per VC: credit' = credit - grant[v] + gnt[v].
- Grant and return on the same VC in the same cycle → unchanged.
- Return while at VC_FIFO_DEPTH-1 with no simultaneous grant → saturate and set err_credit_ovf, which holds until reset.
- A grant is never issued at credit 0, so underflow is impossible.

Queues:
- Simultaneous push and pop on the same VC are allowed when full: the pop frees the slot in the same cycle and in_ready reflects that.
- Pointer wrap is modulo Q_DEPTH.

Mid-operation reset:
- rst=0 discards all queued packets and restores full credits.
- The switch must be reset together with this block.

Decomposition:
- common_pkg gets:
  - `noc_inj_pkt_t` struct `{dest[A_W], data[D_W]}`;
  - function `inj_max_credit(VC_FIFO_DEPTH)`;
  - localparam `DEFAULT_INJ_Q_DEPTH = 4`.
- One sub-module, `noc_inj_vc_fifo`: single-VC, Q_DEPTH-entry circular buffer with full/empty, same reset.
- It is instantiated VC_W times via generate.
- The RR arbiter and credit counters stay in the top.

Test Plan:
1. Reset release; one push (vc=2, dest=3, data=0xA5) → tx_vc_target=4'b0100 and tx_packet={3,0xA5} exactly 2 cycles after push, for 1 cycle; credit[2]=2.
2. Five back-to-back pushes on vc=0 (VC_FIFO_DEPTH=4), no credit returns → exactly 3 packets sent, then tx_vc_target=0. One gnt pulse on bit0 → 4th packet goes out 1 cycle later. Queue holds the 5th.
3. Queues 0,1,3 each hold 2 packets, all with credits → egress order vc 0,1,3,0,1,3 on consecutive cycles with no bubbles.
4. Credit return on vc1 in the same cycle vc1 is granted → credit[1] unchanged; err_credit_ovf stays 0.
5. gnt bit3 pulse with credit[3] already at 3 and queue 3 empty → err_credit_ovf=1 and holds; credit[3] stays 3.
6. Fill queue 2 (Q_DEPTH=4, credit 0) → in_ready=0 for in_vc=2 but 1 for in_vc=0. Assert rst=0 mid-stream → tx_vc_target=0 immediately, idle=1 after release, no stale packets emitted.
